// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and constants for the data-memory bridge.
//   dmb_state_t  - bridge FSM states
//   WA_LSB       - lowest bit of the word address (byte offset bits below it are ignored)
//   WB_DEPTH_DEF - default write-buffer depth
package mips_mem_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD, RDONE} dmb_state_t;
  localparam int WA_LSB = 2;
  localparam int WB_DEPTH_DEF = 2;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: shift-register write buffer with youngest-match address lookup.
//   push/push_addr/push_data - enqueue at the tail
//   pop                      - drop the head (entry 0)
//   count                    - number of valid entries
//   head_addr/head_data      - oldest entry
//   lookup_addr/hit/hit_data - parallel search, youngest matching entry wins
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int AW = 32,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [31:0]   push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [AW-1:0] head_addr,
  output logic [31:0]   head_data,
  input  logic [AW-1:0] lookup_addr,
  output logic          hit,
  output logic [31:0]   hit_data
);
  logic [AW-1:0] a [DEPTH];
  logic [31:0]   d [DEPTH];
  logic [CW-1:0] wi;
  // With a simultaneous pop the tail slides down one slot, so the new entry lands one lower.
  assign wi = pop ? count - CW'(1) : count;
  assign head_addr = a[0];
  assign head_data = d[0];
  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else begin
      count <= count + CW'(push) - CW'(pop);
      for (int i = 0; i < DEPTH; i++)
        if (push && i == int'(wi)) begin
          a[i] <= push_addr;
          d[i] <= push_data;
        end else if (pop) begin
          a[i] <= a[(i + 1) % DEPTH];
          d[i] <= d[(i + 1) % DEPTH];
        end
    end
  end
  // Higher index is younger, so a later match overrides an earlier one.
  always_comb begin
    hit = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (i < int'(count) && a[i] == lookup_addr) begin
        hit = 1'b1;
        hit_data = d[i];
      end
  end
endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: core load/store port to handshaked data RAM with a store buffer.
//   core side: memread, memwrite, addr, writedata -> readdata, stall
//   RAM side : mem_req, mem_we, mem_addr, mem_wdata (registered) <- mem_ack, mem_rdata
module dmem_bridge
  import mips_mem_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEF,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);
  localparam int CW = $clog2(WB_DEPTH + 1);
  dmb_state_t state, nstate;
  logic [CW-1:0] count;
  logic [AW-1:0] wa, head_addr, addr_n;
  logic [31:0]   head_data, hit_data, rlat, rlat_n, wdata_n;
  logic          hit, full, is_load, miss, push, pop, req_n, we_n;
  assign wa = addr & ~AW'((1 << WA_LSB) - 1);
  assign full = count == CW'(WB_DEPTH);
  // A request with both strobes set is handled as a store.
  assign is_load = memread & ~memwrite;
  assign miss = is_load & ~hit;
  assign push = memwrite & ~full;
  // RDONE is the one cycle where a missing load is satisfied from the read latch.
  assign stall = (memwrite & full) | (miss & (state != RDONE));
  assign readdata = (is_load & ~stall) ? (hit ? hit_data : rlat) : '0;
  wb_fifo #(.DEPTH(WB_DEPTH), .AW(AW)) u_fifo (
    .clk(clk), .rst(rst),
    .push(push), .push_addr(wa), .push_data(writedata),
    .pop(pop), .count(count),
    .head_addr(head_addr), .head_data(head_data),
    .lookup_addr(wa), .hit(hit), .hit_data(hit_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rlat <= '0;
    end else begin
      state <= nstate;
      mem_req <= req_n;
      mem_we <= we_n;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
      rlat <= rlat_n;
    end
  end
  always_comb begin
    nstate = state;
    req_n = mem_req;
    we_n = mem_we;
    addr_n = mem_addr;
    wdata_n = mem_wdata;
    rlat_n = rlat;
    pop = 1'b0;
    unique case (state)
      IDLE:
        if (miss) begin
          nstate = RD;
          req_n = 1'b1;
          we_n = 1'b0;
          addr_n = wa;
        end else if (|count || push) begin
          // An empty buffer receiving a store issues that store directly.
          nstate = WR;
          req_n = 1'b1;
          we_n = 1'b1;
          addr_n = |count ? head_addr : wa;
          wdata_n = |count ? head_data : writedata;
        end
      WR:
        if (mem_ack) begin
          nstate = IDLE;
          req_n = 1'b0;
          pop = 1'b1;
        end
      RD:
        if (mem_ack) begin
          nstate = RDONE;
          req_n = 1'b0;
          rlat_n = mem_rdata;
        end
      RDONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge between the MIPS core's load/store port and a multi-cycle, handshaked data RAM. It sits directly downstream of the core and consumes the core's memory request: `memwrite`/`memread`, address (`aluout`) and `writedata`. It returns `readdata` and a `stall` signal. Stores are absorbed into a small write buffer so they normally cost no cycles. Loads are forwarded from the buffer or fetched from RAM while the core is stalled.

## Interface
- `WB_DEPTH`, default 2: write-buffer entries (≥1).
- `AW`, default 32: address width.
- `clk` in, 1: single clock; all state updates on rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `memread` in, 1: core load request.
- `memwrite` in, 1: core store request.
- `addr` in, AW: byte address from ALU; bits [1:0] ignored (word access only).
- `writedata` in, 32: store data.
- `readdata` out, 32: load data; valid when `memread` is high and `stall` is low; otherwise 0.
- `stall` out, 1: core must hold PC and all request inputs stable while high.
- `mem_req` out, 1: RAM request, registered.
- `mem_we` out, 1: 1 for write, 0 for read; valid with `mem_req`.
- `mem_addr` out, AW: word-aligned address ([1:0]=0).
- `mem_wdata` out, 32: write data.
- `mem_ack` in, 1: one-cycle acknowledge from RAM.
- `mem_rdata` in, 32: read data; valid in the `mem_ack` cycle.

## Operation
- **Write buffer**
  - FIFO of {word address, data}, `WB_DEPTH` entries.
  - Entries are pushed by stores and popped by completed RAM writes.
- **Store, buffer not full**
  - Pushed in the same cycle; `stall`=0.
- **Store, buffer full**
  - `stall`=1; the push happens in the first cycle the count is below `WB_DEPTH`.
  - `stall` is computed from the registered count only; there is no combinational path from `mem_ack`.
- **Load hit**
  - Hit: the word address matches a buffer entry. The youngest matching entry wins.
  - `readdata` is driven combinationally from that entry; `stall`=0.
- **Load miss**
  - `stall`=1 until the RAM data has been captured; the buffer is not drained first (no address conflict).
- **FSM states:** IDLE, WR, RD, RDONE.
  - IDLE → RD: a load miss is pending. This has priority over draining.
  - IDLE → WR: otherwise, when the buffer is non-empty. The head entry is issued.
  - WR → IDLE: on `mem_ack`; the head is popped.
  - RD → RDONE: on `mem_ack`; `mem_rdata` is latched.
  - RDONE → IDLE: unconditional. In RDONE, `stall`=0 and `readdata` is the latched value.
  - A load miss that arrives during WR waits for WR's ack, then goes through IDLE → RD.
- **RAM handshake**
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are registered.
  - They stay asserted and stable from the cycle after the state is entered until the cycle `mem_ack` is sampled high.
  - `mem_req` deasserts the cycle after ack.
  - One outstanding request at most.
- **Simultaneous events**
  - Store push and drain pop in the same cycle: count unchanged; the FIFO ordering is preserved.
  - `memread` and `memwrite` both high is illegal. The block treats it as a store, and the bench flags it with an assertion.
- **Reset**
  - FIFO empty, state IDLE.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, read latch=0.
  - `stall`=0 and `readdata`=0 once the reset cycle completes.
  - Reset mid-transaction abandons the request; the RAM must ignore an ack that arrives after reset.

## Timing
- **Store into a non-full buffer:** 0 stall cycles.
- **Drain:** first `mem_req` appears 1 cycle after the push, if IDLE.
- **Load hit:** 0 stall cycles; combinational `readdata`.
- **Load miss, port idle, RAM acking in the first req cycle:**
  - Cycle 0: detect, `stall`=1.
  - Cycle 1: `mem_req`, ack, `stall`=1.
  - Cycle 2: RDONE, `stall`=0, data valid.
  - Total: 2 stall cycles. Each extra RAM wait cycle adds 1.
- **Load miss behind a write in flight:** adds the remaining write latency plus 1 cycle for the IDLE pass.

## Structure
- Shared package `mips_mem_pkg`: FSM state enum `dmb_state_t`, word-address slice constants, default `WB_DEPTH`.
- Sub-module `wb_fifo`:
  - Parameterised depth.
  - Push/pop interface, count, head output.
  - Parallel youngest-match lookup port.
- The bridge holds the FSM, read latch and RAM-port registers.

## Test plan
- **Store then forward**
  - Stimulus: store 0xDEADBEEF @0x100; next cycle load @0x100 with the RAM stalled (ack held low).
  - Required: `readdata`=0xDEADBEEF, `stall`=0 both cycles.
- **Youngest-match**
  - Stimulus: stores 0x1 then 0x2 to @0x104, buffer not yet drained; load @0x107.
  - Required: returns 0x2.
- **Full buffer**
  - Stimulus: 3 back-to-back stores, `WB_DEPTH`=2, RAM ack after 3 cycles.
  - Required: third store sees `stall`=1 until the first drain ack. The RAM sees writes in program order.
- **Load miss latency**
  - Stimulus: empty buffer; RAM holds 0xCAFEF00D @0x200 and acks immediately; load @0x200.
  - Required: `stall` high exactly 2 cycles, then `readdata`=0xCAFEF00D.
- **Miss behind drain**
  - Stimulus: store @0x300, then load miss @0x400 while WR is in flight.
  - Required: the read `mem_req` appears only after the write ack. Correct data is returned; there is never more than one `mem_req` outstanding.
- **Reset mid-RD**
  - Stimulus: assert `rst` while in RD.
  - Required: the next cycle `mem_req`=0, `stall`=0, buffer empty. A later stray `mem_ack` is ignored.
